mem_ctrl: RTL

Byte-serial memory controller that arbitrates the instruction-line refill port and the load/store port onto the single 8-bit RAM/IO bus. It is the parametrised successor of the current memory unit. Line size and tag width are generic, loads are sign/zero-extended, instruction refills can be aborted by a flush, and IO writes hold while the UART buffer is full. The refilled line is handed to an external instruction cache, which is not part of this block.

---
 rtl/mem_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates load/store accesses and instruction line refills
// onto one 8-bit RAM/IO bus, little-endian, one byte per cycle.
module mem_ctrl #(
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned TAG_W      = 3,
    parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full,
    input  logic                    flush_in,
    input  logic                    inst_req,
    input  logic [31:0]             inst_addr,
    output logic                    inst_ready,
    output logic [LINE_BYTES*8-1:0] inst_line,
    output logic [31:0]             inst_line_addr,
    input  logic                    data_req,
    input  logic [TAG_W-1:0]        data_tag,
    input  logic                    data_we,
    input  logic [1:0]              data_size,
    input  logic                    data_signed,
    input  logic [31:0]             data_addr,
    input  logic [31:0]             data_in,
    output logic                    data_ready,
    output logic [31:0]             data_out,
    output logic [TAG_W-1:0]        data_tag_out,
    output logic                    busy
);

    localparam int unsigned OFS_W  = $clog2(LINE_BYTES);
    localparam int unsigned CNT_W  = OFS_W + 1;
    localparam int unsigned LINE_W = LINE_BYTES * 8;

    typedef enum logic [1:0] {StIdle, StDread, StDwrite, StIread} state_e;

    state_e             state_q, state_d;
    logic [31:0]        base_q, base_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         size_q, size_d;
    logic               sgn_q, sgn_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               flushed_q, flushed_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [31:0]        line_addr_q, line_addr_d;
    logic [31:0]        dout_q, dout_d;
    logic               dready_q, dready_d;
    logic               iready_q, iready_d;

    logic               accept_data, accept_inst;
    logic               io_hold, wr_fire, wr_last, rd_done;
    logic [CNT_W-1:0]   data_len;
    logic [OFS_W-1:0]   cap_idx;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sgn);
        logic [31:0] res;
        case (size)
            2'd0:    res = {{24{sgn & raw[7]}}, raw[7:0]};
            2'd1:    res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    always_comb begin
        case (data_size)
            2'd0:    data_len = CNT_W'(1);
            2'd1:    data_len = CNT_W'(2);
            default: data_len = CNT_W'(4);
        endcase
    end

    // Data side wins arbitration; a flush in IDLE blocks any acceptance.
    assign accept_data = (state_q == StIdle) && data_req && !flush_in;
    assign accept_inst = (state_q == StIdle) && !data_req && inst_req && !flush_in;

    assign io_hold = (state_q == StDwrite) && (base_q[17:16] == IO_BASE_HI) && io_buffer_full;
    assign wr_fire = (state_q == StDwrite) && !io_hold;
    assign wr_last = wr_fire && (cnt_q == n_q - CNT_W'(1));
    assign rd_done = (cnt_q == n_q);
    assign cap_idx = OFS_W'(cnt_q - CNT_W'(1));

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept_data) begin
                    state_d = data_we ? StDwrite : StDread;
                end else if (accept_inst) begin
                    state_d = StIread;
                end
            end
            StDread:  if (rd_done) state_d = StIdle;
            StDwrite: if (wr_last) state_d = StIdle;
            StIread:  if (flush_in || rd_done) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Bus outputs
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if (state_q != StIdle) begin
            mem_a = base_q + 32'(cnt_q);
        end
        if (state_q == StDwrite) begin
            mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            mem_wr   = rdy_in && !io_hold;
        end
    end

    // Datapath next-state: reads capture byte k-1 while byte k is addressed
    always_comb begin
        base_d      = base_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        tag_d       = tag_q;
        flushed_d   = flushed_q;
        line_d      = line_q;
        line_addr_d = line_addr_q;
        dout_d      = dout_q;
        dready_d    = 1'b0;
        iready_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept_data) begin
                    base_d    = data_addr;
                    wdata_d   = data_in;
                    size_d    = data_size;
                    sgn_d     = data_signed;
                    tag_d     = data_tag;
                    n_d       = data_len;
                    cnt_d     = '0;
                    flushed_d = 1'b0;
                end else if (accept_inst) begin
                    base_d = inst_addr & ~32'(LINE_BYTES - 1);
                    n_d    = CNT_W'(LINE_BYTES);
                    cnt_d  = '0;
                end
            end
            StDread, StIread: begin
                if (cnt_q != '0) begin
                    line_d[{cap_idx, 3'b000} +: 8] = mem_din;
                end
                if (!rd_done) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (state_q == StDread) begin
                    // A flushed load still finishes its bus sequence, silently
                    flushed_d = flushed_q | flush_in;
                    if (rd_done) begin
                        dout_d   = extend(line_d[31:0], size_q, sgn_q);
                        dready_d = !(flushed_q || flush_in);
                    end
                end else if (rd_done && !flush_in) begin
                    line_addr_d = base_q;
                    iready_d    = 1'b1;
                end
            end
            StDwrite: begin
                if (wr_fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (wr_last) begin
                    dout_d   = '0;
                    dready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Ready pulses self-clear even while frozen so each completion is seen once
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            base_q      <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            tag_q       <= '0;
            flushed_q   <= 1'b0;
            line_q      <= '0;
            line_addr_q <= '0;
            dout_q      <= '0;
            dready_q    <= 1'b0;
            iready_q    <= 1'b0;
        end else begin
            dready_q <= rdy_in && dready_d;
            iready_q <= rdy_in && iready_d;
            if (rdy_in) begin
                base_q      <= base_d;
                cnt_q       <= cnt_d;
                n_q         <= n_d;
                wdata_q     <= wdata_d;
                size_q      <= size_d;
                sgn_q       <= sgn_d;
                tag_q       <= tag_d;
                flushed_q   <= flushed_d;
                line_q      <= line_d;
                line_addr_q <= line_addr_d;
                dout_q      <= dout_d;
            end
        end
    end

    assign inst_ready     = iready_q;
    assign inst_line      = line_q;
    assign inst_line_addr = line_addr_q;
    assign data_ready     = dready_q;
    assign data_out       = dout_q;
    assign data_tag_out   = tag_q;
    assign busy           = (state_q != StIdle);

endmodule
